// File: rtl/dsp_mac_sequencer.sv
// Operand sequencer feeding a DSP48A1 slice set up as a multiply-accumulator.
// Latency: last beat accepted at edge L -> R_VALID from edge L+PIPE_LAT.
// Backpressure: S_READY drops from last beat until the result handshake completes.
//
// Ports: CLK/RST_N (sync, active-low); S_* operand stream (valid/ready, S_LAST marks end of packet);
// DSP_* slice operands, OPMODE, shared clock enable and reset, DSP_P fed back from the slice;
// R_* one accumulated result per packet (valid/ready) with its beat count.
// Optional macro DSP_MAC_SEQ_OVF_EN adds R_OVF: the sum does not fit RES_W signed bits,
// or the beat counter saturated.
module dsp_mac_sequencer #(
  parameter int WIDTH    = 18,
  parameter int PIPE_LAT = 3,
  parameter int CNT_W    = 8,
  parameter int RES_W    = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              S_VALID,
  output logic              S_READY,
  input  logic [WIDTH-1:0]  S_A,
  input  logic [WIDTH-1:0]  S_B,
  input  logic              S_LAST,
  output logic [WIDTH-1:0]  DSP_A,
  output logic [WIDTH-1:0]  DSP_B,
  output logic [7:0]        DSP_OPMODE,
  output logic              DSP_CE,
  output logic              DSP_RST,
  input  logic [47:0]       DSP_P,
  output logic              R_VALID,
  input  logic              R_READY,
  output logic [47:0]       R_DATA,
  output logic [CNT_W-1:0]  R_COUNT
`ifdef DSP_MAC_SEQ_OVF_EN
  ,
  output logic              R_OVF
`endif
);

  if (PIPE_LAT < 2 || PIPE_LAT > 7) begin : g_bad_pipe_lat
    $error("dsp_mac_sequencer: PIPE_LAT must be 2..7");
  end
  if (RES_W < 2 || RES_W > 48) begin : g_bad_res_w
    $error("dsp_mac_sequencer: RES_W must be 2..48");
  end

  typedef enum logic [1:0] {ST_ACC, ST_DRAIN, ST_RESULT} state_t;

  localparam logic [2:0]       DRAIN_LOAD = 3'(PIPE_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [7:0]       OP_CLEAR   = 8'h01;  // X=M, Z=0
  localparam logic [7:0]       OP_ACCUM   = 8'h09;  // X=M, Z=P

  state_t           state;
  logic             first;
  logic [2:0]       drain_cnt;
  logic [CNT_W-1:0] beat_cnt;
  logic             in_acc;
  logic             accept;

  // Gating with RST_N keeps the handshake and slice enables quiet while reset is held.
  assign in_acc  = (state == ST_ACC) && RST_N;
  assign accept  = S_VALID && in_acc;
  assign S_READY = in_acc;
  assign DSP_A   = in_acc ? S_A : '0;
  assign DSP_B   = in_acc ? S_B : '0;
  // Idle ACC cycles freeze the whole slice so gaps never disturb the sum.
  assign DSP_CE  = accept || ((state == ST_DRAIN) && RST_N);
  assign DSP_RST = ~RST_N;

`ifdef DSP_MAC_SEQ_OVF_EN
  logic sum_fits;
  // The sum fits when every bit above the RES_W sign bit matches it.
  assign sum_fits = (&DSP_P[47:RES_W-1]) || !(|DSP_P[47:RES_W-1]);
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= ST_ACC;
      first      <= 1'b1;
      drain_cnt  <= '0;
      beat_cnt   <= '0;
      DSP_OPMODE <= 8'h00;
      R_VALID    <= 1'b0;
      R_DATA     <= '0;
      R_COUNT    <= '0;
`ifdef DSP_MAC_SEQ_OVF_EN
      R_OVF      <= 1'b0;
`endif
    end else begin
      case (state)
        ST_ACC: begin
          if (accept) begin
            // The slice registers OPMODE one CE later than A/B, so this beat's
            // opmode reaches the post-adder together with its product from M.
            DSP_OPMODE <= first ? OP_CLEAR : OP_ACCUM;
            first      <= 1'b0;
            if (beat_cnt != CNT_MAX) beat_cnt <= beat_cnt + 1'b1;
            if (S_LAST) begin
              state     <= ST_DRAIN;
              drain_cnt <= DRAIN_LOAD;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == 3'd0) begin
            state   <= ST_RESULT;
            R_VALID <= 1'b1;
            R_DATA  <= DSP_P;
            R_COUNT <= beat_cnt;
`ifdef DSP_MAC_SEQ_OVF_EN
            R_OVF   <= !sum_fits || (beat_cnt == CNT_MAX);
`endif
          end else begin
            drain_cnt <= drain_cnt - 3'd1;
          end
        end
        ST_RESULT: begin
          if (R_READY) begin
            R_VALID  <= 1'b0;
            state    <= ST_ACC;
            first    <= 1'b1;
            beat_cnt <= '0;
          end
        end
        default: state <= ST_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: directed packets through a behavioural DSP48A1 MAC model.
// Expected results are queued at stimulus time; a negedge monitor pops and compares them.
// Also checks reset values, opmode skew, idle CE, result hold under backpressure, latency.
module tb_dsp_mac_sequencer;
  localparam int PIPE_LAT = 3;

  typedef struct {
    logic [47:0] data;
    logic [7:0]  count;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        RST_N;
  logic        S_VALID;
  logic        S_READY;
  logic [17:0] S_A;
  logic [17:0] S_B;
  logic        S_LAST;
  logic [17:0] DSP_A;
  logic [17:0] DSP_B;
  logic [7:0]  DSP_OPMODE;
  logic        DSP_CE;
  logic        DSP_RST;
  logic [47:0] DSP_P;
  logic        R_VALID;
  logic        R_READY;
  logic [47:0] R_DATA;
  logic [7:0]  R_COUNT;
`ifdef DSP_MAC_SEQ_OVF_EN
  logic        R_OVF;
`endif

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_acc = 0;
  exp_t sb[$];
  logic [7:0] op_log[$];
  logic rec_op = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dsp_mac_sequencer dut (
    .CLK(clk), .RST_N(RST_N),
    .S_VALID(S_VALID), .S_READY(S_READY), .S_A(S_A), .S_B(S_B), .S_LAST(S_LAST),
    .DSP_A(DSP_A), .DSP_B(DSP_B), .DSP_OPMODE(DSP_OPMODE), .DSP_CE(DSP_CE),
    .DSP_RST(DSP_RST), .DSP_P(DSP_P),
    .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA), .R_COUNT(R_COUNT)
`ifdef DSP_MAC_SEQ_OVF_EN
    , .R_OVF(R_OVF)
`endif
  );

  // Behavioural slice: A1/B1 -> M -> P with registered OPMODE, one shared CE.
  logic signed [17:0] a_r, b_r;
  logic signed [35:0] prod;
  logic signed [47:0] m_r, p_r;
  logic [7:0]         op_r;
  assign prod  = a_r * b_r;
  assign DSP_P = p_r;
  always @(posedge clk) begin
    if (DSP_RST) begin
      a_r <= '0; b_r <= '0; m_r <= '0; p_r <= '0; op_r <= '0;
    end else if (DSP_CE) begin
      a_r  <= DSP_A;
      b_r  <= DSP_B;
      m_r  <= 48'(prod);
      op_r <= DSP_OPMODE;
      p_r  <= ((op_r[3:2] == 2'b10) ? p_r : 48'sd0) + m_r;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [47:0] d, input logic [7:0] c, input logic o);
    exp_t e;
    e.data = d; e.count = c; e.ovf = o;
    sb.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send_beat(input logic signed [17:0] a, input logic signed [17:0] b,
                           input logic last);
    int n = 0;
    S_VALID = 1'b1; S_A = a; S_B = b; S_LAST = last;
    @(negedge clk);
    while (!S_READY && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!S_READY) chk("beat_accept_timeout", 64'(S_READY), 64'd1);
    @(posedge clk); #1;
    last_acc = cyc;
    S_VALID = 1'b0; S_LAST = 1'b0;
  endtask

  task automatic wait_results();
    int n = 0;
    while ((sb.size() != 0 || R_VALID) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("results_drained", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // Monitor: pops the scoreboard on each result handshake and checks hold/latency.
  logic        pv = 1'b0, pr = 1'b0;
  logic [47:0] pd;
  logic [7:0]  pc;
  always @(negedge clk) begin
    if (RST_N) begin
      if (R_VALID) chk("s_ready_low_during_result", 64'(S_READY), 64'd0);
      if (pv && !pr) begin
        chk("hold_r_valid", 64'(R_VALID), 64'd1);
        chk("hold_r_data", 64'(R_DATA), 64'(pd));
        chk("hold_r_count", 64'(R_COUNT), 64'(pc));
      end
      if (R_VALID && !pv) chk("result_latency", 64'(cyc - last_acc), 64'(PIPE_LAT));
      if (R_VALID && R_READY) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 64'(R_VALID), 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("r_data", 64'(R_DATA), 64'(e.data));
          chk("r_count", 64'(R_COUNT), 64'(e.count));
`ifdef DSP_MAC_SEQ_OVF_EN
          chk("r_ovf", 64'(R_OVF), 64'(e.ovf));
`endif
        end
      end
      pv = R_VALID; pr = R_READY; pd = R_DATA; pc = R_COUNT;
    end else begin
      pv = 1'b0; pr = 1'b0;
    end
    if (rec_op && DSP_CE) op_log.push_back(DSP_OPMODE);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] op_exp [5];
    op_exp[0] = 8'h00; op_exp[1] = 8'h01; op_exp[2] = 8'h09; op_exp[3] = 8'h09; op_exp[4] = 8'h09;

    // Reset held with S_VALID high: nothing accepted, everything at reset values.
    RST_N = 1'b0; S_VALID = 1'b1; S_A = 18'd5; S_B = 18'd5; S_LAST = 1'b0; R_READY = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", 64'(S_READY), 64'd0);
    chk("rst_r_valid", 64'(R_VALID), 64'd0);
    chk("rst_r_data", 64'(R_DATA), 64'd0);
    chk("rst_r_count", 64'(R_COUNT), 64'd0);
    chk("rst_dsp_ce", 64'(DSP_CE), 64'd0);
    chk("rst_dsp_a", 64'(DSP_A), 64'd0);
    chk("rst_dsp_b", 64'(DSP_B), 64'd0);
    chk("rst_dsp_opmode", 64'(DSP_OPMODE), 64'h00);
    chk("rst_dsp_rst", 64'(DSP_RST), 64'd1);
`ifdef DSP_MAC_SEQ_OVF_EN
    chk("rst_r_ovf", 64'(R_OVF), 64'd0);
`endif
    @(posedge clk); #1;
    RST_N = 1'b1; S_VALID = 1'b0;
    @(negedge clk);
    chk("release_s_ready", 64'(S_READY), 64'd1);
    chk("release_dsp_rst", 64'(DSP_RST), 64'd0);
    @(posedge clk); #1;

    // Contiguous packet: 1*2+2*2+3*2+4*2 = 20, opmode skew on CE cycles.
    rec_op = 1'b1;
    push_exp(48'd20, 8'd4, 1'b0);
    send_beat(18'sd1, 18'sd2, 1'b0);
    send_beat(18'sd2, 18'sd2, 1'b0);
    send_beat(18'sd3, 18'sd2, 1'b0);
    send_beat(18'sd4, 18'sd2, 1'b1);
    wait_results();
    rec_op = 1'b0;
    chk("opmode_log_len_ge5", 64'(op_log.size() >= 5), 64'd1);
    for (int i = 0; i < 5 && i < op_log.size(); i++)
      chk($sformatf("opmode_ce_%0d", i), 64'(op_log[i]), 64'(op_exp[i]));

    // Back-to-back single-beat packets: accumulator clears on each first beat.
    push_exp(48'd15, 8'd1, 1'b0);
    push_exp(48'hFFFF_FFFF_FFF2, 8'd1, 1'b0);
    send_beat(18'sd3, 18'sd5, 1'b1);
    send_beat(-18'sd2, 18'sd7, 1'b1);
    wait_results();

    // Same 4-beat packet with an idle cycle after each non-final beat.
    push_exp(48'd20, 8'd4, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      send_beat(18'(i), 18'sd2, i == 4);
      if (i != 4) begin
        @(negedge clk);
        chk("gap_dsp_ce_idle", 64'(DSP_CE), 64'd0);
        @(posedge clk); #1;
      end
    end
    wait_results();

    // Backpressure: result held 5 cycles, next packet only after the handshake.
    R_READY = 1'b0;
    push_exp(-48'sd11, 8'd2, 1'b0);
    send_beat(18'sd5, -18'sd3, 1'b0);
    send_beat(18'sd2, 18'sd2, 1'b1);
    begin
      int n = 0;
      @(negedge clk);
      while (!R_VALID && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    chk("bp_r_valid_seen", 64'(R_VALID), 64'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_s_ready_low", 64'(S_READY), 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    R_READY = 1'b1;
    push_exp(48'd49, 8'd1, 1'b0);
    send_beat(18'sd7, 18'sd7, 1'b1);
    wait_results();

    // Reset in DRAIN discards the packet: no result may appear.
    send_beat(18'sd3, 18'sd5, 1'b1);
    RST_N = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    RST_N = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("drain_reset_no_result", 64'(R_VALID), 64'd0);
    end
    @(posedge clk); #1;

    // Large products: 2*131071^2 exceeds 32 signed bits; then a tiny packet.
    push_exp(48'd34359214082, 8'd2, 1'b1);
    send_beat(18'sd131071, 18'sd131071, 1'b0);
    send_beat(18'sd131071, 18'sd131071, 1'b1);
    push_exp(48'd1, 8'd1, 1'b0);
    send_beat(18'sd1, 18'sd1, 1'b1);
    wait_results();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
